ifetch: RTL and testbench

Instruction fetch stage sitting directly upstream of `icache`. It owns the fetch index (halfword cell number), drives the cache's `index`/`not_enable` inputs, and captures the 16-bit instruction words the cache returns one cycle later. Captured words go into a small prefetch FIFO that feeds decode through a valid/ready handshake. Branch redirects flush everything in flight.

---
 rtl/ifetch.sv | 105 ++++++++++
 tb/tb_ifetch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch.sv
// Instruction fetch stage: drives icache reads, captures returned
// halfwords into a prefetch FIFO and hands them to decode.
module ifetch #(
    parameter logic [31:0] RESET_INDEX = 32'd0,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        not_reset,
    input  logic        branch_valid,
    input  logic [31:0] branch_index,
    output logic        cache_not_enable,
    output logic [31:0] cache_index,
    input  logic [15:0] cache_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_data,
    output logic [31:0] instr_index
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_q, fetch_d;
    logic          infl_v_q, infl_v_d;
    logic [31:0]   infl_idx_q, infl_idx_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [15:0] data_q [FIFO_DEPTH];
    logic [31:0] idx_q  [FIFO_DEPTH];

    logic [CW-1:0] occ;
    logic          issue;
    logic          push;
    logic          pop;

    // Occupancy counts the in-flight read so a full FIFO never overflows
    assign occ   = cnt_q + CW'(infl_v_q);
    assign issue = not_reset && !branch_valid && (occ < CW'(FIFO_DEPTH));
    assign push  = infl_v_q && !branch_valid;
    assign pop   = instr_valid && instr_ready && !branch_valid;

    assign cache_not_enable = !issue;
    assign cache_index      = fetch_q;

    assign instr_valid = (cnt_q != '0);
    assign instr_data  = instr_valid ? data_q[rd_q] : 16'd0;
    assign instr_index = instr_valid ? idx_q[rd_q]  : 32'd0;

    always_comb begin
        fetch_d    = fetch_q;
        infl_v_d   = 1'b0;
        infl_idx_d = infl_idx_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        if (branch_valid) begin
            fetch_d = branch_index;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else begin
            if (issue) begin
                infl_v_d   = 1'b1;
                infl_idx_d = fetch_q;
                fetch_d    = fetch_q + 32'd1;
            end
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            fetch_q    <= RESET_INDEX;
            infl_v_q   <= 1'b0;
            infl_idx_q <= 32'd0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            fetch_q    <= fetch_d;
            infl_v_q   <= infl_v_d;
            infl_idx_q <= infl_idx_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Storage needs no reset: reads are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q] <= cache_data;
            idx_q[wr_q]  <= infl_idx_q;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch against a queue-level reference model
// and a one-cycle-latency icache model.
module tb_ifetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RST   = 32'd10;

    logic        clk = 1'b0;
    logic        not_reset;
    logic        branch_valid;
    logic [31:0] branch_index;
    logic        cache_not_enable;
    logic [31:0] cache_index;
    logic [15:0] cache_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_data;
    logic [31:0] instr_index;

    ifetch #(.RESET_INDEX(RST), .FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .not_reset        (not_reset),
        .branch_valid     (branch_valid),
        .branch_index     (branch_index),
        .cache_not_enable (cache_not_enable),
        .cache_index      (cache_index),
        .cache_data       (cache_data),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr_data       (instr_data),
        .instr_index      (instr_index)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] word_of(input logic [31:0] i);
        return i[15:0] ^ {i[23:16], i[31:24]} ^ 16'hC3A5;
    endfunction

    // icache: data for the presented index appears the next cycle
    always @(posedge clk)
        cache_data <= !cache_not_enable ? word_of(cache_index)
                                        : 16'($urandom);

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a queue of word indices, one pending read, next index
    logic [31:0] q[$];
    bit          pv;
    logic [31:0] pidx;
    logic [31:0] nxt;

    logic        obs_valid;
    logic        obs_cne;
    logic [31:0] obs_idx;
    logic [31:0] popped[$];

    task automatic model_reset();
        q.delete();
        pv  = 0;
        nxt = RST;
    endtask

    task automatic model_tick();
        bit iss;
        if (!not_reset) begin
            model_reset();
            return;
        end
        if (branch_valid) begin
            q.delete();
            pv  = 0;
            nxt = branch_index;
            return;
        end
        iss = (q.size() + int'(pv)) < DEPTH;
        if (q.size() != 0 && instr_ready) void'(q.pop_front());
        if (pv) q.push_back(pidx);
        pv   = iss;
        pidx = nxt;
        if (iss) nxt = nxt + 32'd1;
    endtask

    task automatic compare_outputs();
        bit          exp_iss;
        logic [31:0] hd;
        exp_iss = not_reset && !branch_valid
                  && ((q.size() + int'(pv)) < DEPTH);
        hd = (q.size() != 0) ? q[0] : 32'd0;
        check("cne",   32'(cache_not_enable), 32'(!exp_iss));
        check("cidx",  cache_index, nxt);
        check("valid", 32'(instr_valid), 32'(q.size() != 0));
        check("iidx",  instr_index, hd);
        check("idata", 32'(instr_data),
              (q.size() != 0) ? 32'(word_of(hd)) : 32'd0);
    endtask

    task automatic cycle(input logic br, input logic [31:0] bi,
                         input logic rdy);
        branch_valid = br;
        branch_index = bi;
        instr_ready  = rdy;
        @(negedge clk);
        compare_outputs();
        obs_valid = instr_valid;
        obs_cne   = cache_not_enable;
        obs_idx   = instr_index;
        if (instr_valid && instr_ready && !branch_valid)
            popped.push_back(instr_index);
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic mid_reset();
        #3 not_reset = 1'b0;
        #1;
        check("mr_valid", 32'(instr_valid), 32'd0);
        check("mr_cne",   32'(cache_not_enable), 32'd1);
        check("mr_iidx",  instr_index, 32'd0);
        model_reset();
        cycle(1'b0, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        not_reset = 1'b1;
    endtask

    initial begin
        int n_iss;
        int pct;
        not_reset    = 1'b0;
        branch_valid = 1'b0;
        branch_index = 32'd0;
        instr_ready  = 1'b0;
        model_reset();
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b0);
        not_reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (i == 1) check("rel_v1", 32'(obs_valid), 32'd0);
            if (i == 2) check("rel_idx2", obs_idx, 32'd10);
            if (i == 4) check("rel_idx4", obs_idx, 32'd12);
        end

        cycle(1'b1, 32'd0, 1'b0);
        n_iss = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 32'd0, 1'b0);
            if (!obs_cne) n_iss++;
        end
        check("bp_issues", 32'(n_iss), 32'd4);
        check("bp_full", 32'(obs_valid), 32'd1);
        popped.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            check("bp_pop", (popped.size() > i) ? popped[i] : 32'hDEAD,
                  32'(i));

        cycle(1'b1, 32'h40, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h100, 1'b1);
        cycle(1'b0, 32'd0, 1'b1);
        check("br_b1", 32'(obs_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        check("br_b2", 32'(obs_valid), 32'd0);
        cycle(1'b0, 32'd0, 1'b1);
        check("br_b3", obs_idx, 32'h100);

        cycle(1'b1, 32'hFFFF_FFFE, 1'b1);
        popped.delete();
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 4; i++)
            check("wrap", (popped.size() > i) ? popped[i] : 32'hDEAD,
                  32'hFFFF_FFFE + 32'(i));

        mid_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0, 1'b1);
            if (i == 2) check("mr_restart", obs_idx, RST);
        end

        pct = 70;
        for (int i = 0; i < 2000; i++) begin
            logic        br;
            logic [31:0] bi;
            if (i % 100 == 0) pct = $urandom_range(0, 100);
            br = ($urandom_range(0, 19) == 0);
            bi = ($urandom_range(0, 3) == 0)
                 ? 32'hFFFF_FFFC + 32'($urandom_range(0, 3))
                 : 32'($urandom);
            if (i % 400 == 399) mid_reset();
            else cycle(br, bi, $urandom_range(0, 99) < pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
